// File: rtl/branch_ctrl_pkg.sv
// Shared RISC-V branch constants: funct3 encodings and the branch controller FSM state encoding.
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // funct3[1] separates the unsigned forms (BLTU/BGEU) from the signed ones.
  function automatic logic f3_unsigned(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational taken/illegal decode from funct3 and the comparator flags.
// Zero latency, no state, no backpressure.
module branch_cond_decode
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       beq,
  input  logic       blt,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = beq;
      F3_BNE:           taken = !beq;
      F3_BLT, F3_BLTU:  taken = blt;
      F3_BGE, F3_BGEU:  taken = !blt;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution FSM: result strobe one cycle after EVAL, then FLUSH_CYCLES of squash when taken.
// req_ready is low in EVAL/FLUSH (requester holds). BRANCH_STATS_EN adds stat_total/stat_taken counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic        cmp_un,
  output logic [31:0] cmp_rr1,
  output logic [31:0] cmp_rr2,
  input  logic        cmp_beq,
  input  logic        cmp_blt,
  output logic        res_valid,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        illegal,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken
`endif
);

  localparam bit             FLUSH_EN = (FLUSH_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = FLUSH_EN ? CNT_W'(FLUSH_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]  f3_q;
  logic [31:0] rs1_q, rs2_q, pc_q, imm_q;

  logic        accept;
  logic        leave_eval;
  logic        dec_taken, dec_illegal;
  logic [31:0] target_sum;

  branch_cond_decode u_decode (
    .funct3  (f3_q),
    .beq     (cmp_beq),
    .blt     (cmp_blt),
    .taken   (dec_taken),
    .illegal (dec_illegal)
  );

  assign cmp_un     = f3_unsigned(f3_q);
  assign cmp_rr1    = rs1_q;
  assign cmp_rr2    = rs2_q;
  assign target_sum = pc_q + imm_q;

  assign req_ready  = (state_q == IDLE);
  assign flush      = (state_q == FLUSH);
  assign accept     = req_valid && req_ready;
  assign leave_eval = (state_q == EVAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = EVAL;
      end
      EVAL: begin
        // Illegal encodings decode as not-taken, so they never enter FLUSH.
        if (dec_taken && FLUSH_EN) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      f3_q  <= funct3;
      rs1_q <= rs1_val;
      rs2_q <= rs2_val;
      pc_q  <= pc;
      imm_q <= imm;
    end
  end

  // Result fields hold their value until the next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
      illegal    <= 1'b0;
    end else begin
      res_valid <= leave_eval;
      if (leave_eval) begin
        res_taken  <= dec_taken;
        res_target <= target_sum;
        illegal    <= dec_illegal;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (leave_eval) begin
      stat_total <= stat_total + 32'd1;
      if (dec_taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized branches against a reference model.
module tb_branch_ctrl;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, pc, imm;
  logic        cmp_un;
  logic [31:0] cmp_rr1, cmp_rr2;
  logic        cmp_beq, cmp_blt;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        illegal, flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total, stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  // Expected held result fields and statistics since last reset.
  logic        exp_taken_q;
  logic [31:0] exp_target_q;
  logic        exp_illegal_q;
  int unsigned n_total, n_taken;

  branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .pc         (pc),
    .imm        (imm),
    .cmp_un     (cmp_un),
    .cmp_rr1    (cmp_rr1),
    .cmp_rr2    (cmp_rr2),
    .cmp_beq    (cmp_beq),
    .cmp_blt    (cmp_blt),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_target (res_target),
    .illegal    (illegal),
    .flush      (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  // External comparator the block drives.
  assign cmp_beq = (cmp_rr1 == cmp_rr2);
  assign cmp_blt = cmp_un ? (cmp_rr1 < cmp_rr2) : ($signed(cmp_rr1) < $signed(cmp_rr2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_taken_q   = 1'b0;
    exp_target_q  = '0;
    exp_illegal_q = 1'b0;
    n_total       = 0;
    n_taken       = 0;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Present a request at a negedge, let it be accepted, then scramble the inputs.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i);
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk1("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1;
    funct3    = f3;
    rs1_val   = a;
    rs2_val   = b;
    pc        = p;
    imm       = i;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    funct3    = 3'($urandom);
    rs1_val   = $urandom;
    rs2_val   = $urandom;
    pc        = $urandom;
    imm       = $urandom;
  endtask

  task automatic do_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic [31:0] i);
    logic        tk, il, fl;
    logic [31:0] tgt;
    tk  = ref_taken(f3, a, b);
    il  = ref_illegal(f3);
    tgt = p + i;
    fl  = tk && (FC > 0);
    send(f3, a, b, p, i);
    chk1("eval_req_ready", req_ready, 1'b0);
    chk1("eval_res_valid", res_valid, 1'b0);
    chk1("eval_flush", flush, 1'b0);
    chk32("eval_cmp_rr1", cmp_rr1, a);
    chk32("eval_cmp_rr2", cmp_rr2, b);
    chk1("eval_cmp_un", cmp_un, f3[1]);
    chk1("hold_taken", res_taken, exp_taken_q);
    chk32("hold_target", res_target, exp_target_q);
    chk1("hold_illegal", illegal, exp_illegal_q);
    @(negedge clk);
    chk1("res_valid", res_valid, 1'b1);
    chk1("res_taken", res_taken, tk);
    chk32("res_target", res_target, tgt);
    chk1("res_illegal", illegal, il);
    chk1("res_flush", flush, fl);
    chk1("res_req_ready", req_ready, !fl);
    exp_taken_q   = tk;
    exp_target_q  = tgt;
    exp_illegal_q = il;
    n_total++;
    if (tk) n_taken++;
`ifdef BRANCH_STATS_EN
    chk32("stat_total", stat_total, n_total);
    chk32("stat_taken", stat_taken, n_taken);
`endif
    if (fl) begin
      // A request raised during FLUSH must wait.
      req_valid = 1'b1;
      for (int k = 1; k < FC; k++) begin
        @(negedge clk);
        chk1("flush_hi", flush, 1'b1);
        chk1("flush_req_ready", req_ready, 1'b0);
        chk1("flush_res_valid", res_valid, 1'b0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk1("flush_end", flush, 1'b0);
      chk1("flush_end_ready", req_ready, 1'b1);
      chk1("flush_end_res_valid", res_valid, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    funct3    = '0;
    rs1_val   = '0;
    rs2_val   = '0;
    pc        = '0;
    imm       = '0;
    model_reset();

    // Reset state.
    do_reset(3);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_res_taken", res_taken, 1'b0);
    chk32("rst_res_target", res_target, 32'h0);
    chk1("rst_illegal", illegal, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk32("rst_cmp_rr1", cmp_rr1, 32'h0);
    chk1("rst_cmp_un", cmp_un, 1'b0);
`ifdef BRANCH_STATS_EN
    chk32("rst_stat_total", stat_total, 32'h0);
`endif

    // Taken BEQ with flush.
    do_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);

    // Signed vs unsigned less-than on the same operands.
    do_branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h8);
    do_branch(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8);

    // Back-to-back not-taken BNE.
    do_branch(3'b001, 32'd9, 32'd9, 32'h400, 32'h4);
    do_branch(3'b001, 32'd9, 32'd9, 32'h404, 32'h4);
    do_branch(3'b001, 32'd9, 32'd9, 32'h408, 32'h4);

    // Illegal encodings and target wrap-around.
    do_branch(3'b010, 32'd1, 32'd1, 32'h500, 32'h10);
    do_branch(3'b011, 32'd2, 32'd1, 32'h600, 32'h10);
    do_branch(3'b101, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h20);

    // Stats scenario: 3 taken, 2 not taken after a clean reset.
    do_reset(2);
    do_branch(3'b000, 32'd3, 32'd3, 32'h10, 32'h10);
    do_branch(3'b000, 32'd3, 32'd4, 32'h20, 32'h10);
    do_branch(3'b111, 32'd8, 32'd2, 32'h30, 32'h10);
    do_branch(3'b110, 32'd8, 32'd2, 32'h40, 32'h10);
    do_branch(3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h50, 32'h10);
`ifdef BRANCH_STATS_EN
    chk32("stats_total_5", stat_total, 32'd5);
    chk32("stats_taken_3", stat_taken, 32'd3);
`endif

    // Randomized branches.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_branch(f3, a, b, $urandom, $urandom);
    end

    // Reset during EVAL aborts the result.
    send(3'b000, 32'd1, 32'd1, 32'h700, 32'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk1("abort_eval_res_valid", res_valid, 1'b0);
    chk1("abort_eval_ready", req_ready, 1'b1);
    chk1("abort_eval_flush", flush, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk1("abort_eval_quiet", res_valid, 1'b0);
    end

    // Reset in the first FLUSH cycle.
    send(3'b000, 32'd6, 32'd6, 32'h800, 32'h4);
    @(negedge clk);
    chk1("pre_abort_flush", flush, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk1("abort_flush_flush", flush, 1'b0);
    chk1("abort_flush_ready", req_ready, 1'b1);
    chk1("abort_flush_res_valid", res_valid, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("abort_flush_quiet", res_valid, 1'b0);
      chk1("abort_flush_noflush", flush, 1'b0);
    end

    // Reset wins over a simultaneous request.
    rst       = 1'b1;
    req_valid = 1'b1;
    funct3    = 3'b000;
    rs1_val   = 32'd1;
    rs2_val   = 32'd1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    chk1("rst_prio_ready", req_ready, 1'b1);
    @(negedge clk);
    chk1("rst_prio_res_valid", res_valid, 1'b0);

    // Normal operation resumes afterwards.
    do_branch(3'b000, 32'd2, 32'd2, 32'h900, 32'h40);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
